pipe_lanes: RTL and testbench

Parametrised multi-lane in-order pipeline register array that replaces the fixed dual-lane inter-stage registers between fetch and writeback. It holds `STAGES` ranks of `LANES` slots, each with a valid bit and a `DATA_W`-bit payload. It resolves per-stage stall requests into back-propagated holds and bubbles, and applies per-stage flushes. It supports a per-lane split at one configurable stage, generalising the issue-stage special stall, and counts retired lane-slots.

---
 rtl/pipe_lanes_pkg.sv | 23 ++
 rtl/pipe_stage_reg.sv | 51 +++++
 rtl/pipe_lanes.sv | 117 +++++++++++
 tb/tb_pipe_lanes.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_lanes_pkg.sv
// Shared constants and helpers for the multi-lane pipeline register array.
package pipe_lanes_pkg;

  localparam int PIPE_STAGES_DEF    = 5;
  localparam int PIPE_LANES_DEF     = 2;
  localparam int PIPE_SPLIT_STG_DEF = 2;
  localparam int PIPE_DATA_W_DEF    = 64;

  // Rank-wide controls; clear has priority over load inside the rank.
  typedef struct packed {
    logic clear;
    logic load;
  } stg_ctrl_t;

  // Lanes are capped at 8, so a fixed 8-bit popcount covers every config.
  function automatic logic [31:0] popcnt8(input logic [7:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline rank: LANES valid bits plus payloads, with clear/load and
// per-lane bubble (load invalid) and keep (ignore the load) masks.
module pipe_stage_reg
  import pipe_lanes_pkg::*;
#(
  parameter int LANES  = PIPE_LANES_DEF,
  parameter int DATA_W = PIPE_DATA_W_DEF
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  stg_ctrl_t                     ctrl_i,
  input  logic [LANES-1:0]              bubble_i,
  input  logic [LANES-1:0]              keep_i,
  input  logic [LANES-1:0]              valid_i,
  input  logic [LANES-1:0][DATA_W-1:0]  data_i,
  output logic [LANES-1:0]              valid_o,
  output logic [LANES-1:0][DATA_W-1:0]  data_o
);

  logic [LANES-1:0]             valid_q, valid_d;
  logic [LANES-1:0][DATA_W-1:0] data_q, data_d;

  // Next state per lane: clear drops valid but keeps payload; kept lanes hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int l = 0; l < LANES; l++) begin
      if (ctrl_i.clear) begin
        valid_d[l] = 1'b0;
      end else if (ctrl_i.load && !keep_i[l]) begin
        valid_d[l] = valid_i[l] & ~bubble_i[l];
        data_d[l]  = data_i[l];
      end
    end
  end

  // Rank registers with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_lanes.sv
// Multi-lane in-order pipeline register array: stall back-propagation,
// flushes, a per-lane split at one stage, and a retired-slot counter.
module pipe_lanes
  import pipe_lanes_pkg::*;
#(
  parameter int LANES     = PIPE_LANES_DEF,
  parameter int STAGES    = PIPE_STAGES_DEF,
  parameter int DATA_W    = PIPE_DATA_W_DEF,
  parameter int SPLIT_STG = PIPE_SPLIT_STG_DEF
) (
  input  logic                            clock_i,
  input  logic                            reset_n_i,
  input  logic [LANES-1:0]                in_valid_i,
  input  logic [LANES*DATA_W-1:0]         in_data_i,
  output logic                            in_ready_o,
  input  logic [STAGES-1:0]               stall_i,
  input  logic [STAGES-1:0]               flush_i,
  input  logic [LANES-1:0]                split_i,
  output logic [STAGES*LANES-1:0]         stage_valid_o,
  output logic [STAGES*LANES*DATA_W-1:0]  stage_data_o,
  output logic [STAGES-1:0]               adv_o,
  output logic [31:0]                     retire_cnt_o
);

  logic [STAGES-1:0] hold, flushed, adv;
  logic              split_act, split_eff;

  logic [STAGES-1:0][LANES-1:0]             stg_v, src_v, bub, keep;
  logic [STAGES-1:0][LANES-1:0][DATA_W-1:0] stg_d, src_d;
  stg_ctrl_t [STAGES-1:0]                   ctrl;

  logic [LANES-1:0] ret;
  logic [7:0]       ret8;
  logic [31:0]      retire_cnt_q, retire_cnt_d;

  // Holds and flushes propagate toward younger stages; the split freezes
  // everything below the split stage while the split stage itself drains.
  always_comb begin
    hold    = '0;
    flushed = '0;
    hold[STAGES-1]    = stall_i[STAGES-1];
    flushed[STAGES-1] = flush_i[STAGES-1];
    for (int s = STAGES - 2; s >= 0; s--) begin
      hold[s]    = stall_i[s] | hold[s+1];
      flushed[s] = flush_i[s] | flushed[s+1];
    end
    split_act = (|split_i) & ~hold[SPLIT_STG];
    split_eff = split_act & ~flushed[SPLIT_STG];
    for (int s = 0; s < STAGES; s++)
      adv[s] = ~hold[s] & ~(split_act && (s < SPLIT_STG));
  end

  // Per-rank controls: source selection, bubbles behind non-advancing or
  // flushed stages, and the lane masks of an active split.
  always_comb begin
    bub   = '0;
    keep  = '0;
    src_v = '0;
    src_d = '0;
    for (int s = 0; s < STAGES; s++) begin
      ctrl[s].clear = flushed[s];
      ctrl[s].load  = adv[s];
    end
    src_v[0] = in_valid_i;
    src_d[0] = in_data_i;
    for (int s = 1; s < STAGES; s++) begin
      src_v[s] = stg_v[s-1];
      src_d[s] = stg_d[s-1];
      if (!adv[s-1] || flush_i[s-1]) bub[s] = '1;
    end
    if (split_eff) begin
      // Split lanes stay put; the others leave the split stage invalid.
      keep[SPLIT_STG] = split_i;
      bub[SPLIT_STG]  = bub[SPLIT_STG] | ~split_i;
      bub[SPLIT_STG+1] = bub[SPLIT_STG+1] | split_i;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    pipe_stage_reg #(
      .LANES  (LANES),
      .DATA_W (DATA_W)
    ) u_reg (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .ctrl_i    (ctrl[s]),
      .bubble_i  (bub[s]),
      .keep_i    (keep[s]),
      .valid_i   (src_v[s]),
      .data_i    (src_d[s]),
      .valid_o   (stg_v[s]),
      .data_o    (stg_d[s])
    );
  end

  // Retiring lanes: oldest stage valid and neither stalled nor flushed.
  always_comb begin
    ret  = stg_v[STAGES-1] & {LANES{~stall_i[STAGES-1] & ~flush_i[STAGES-1]}};
    ret8 = '0;
    ret8[LANES-1:0] = ret;
    retire_cnt_d = retire_cnt_q + popcnt8(ret8);
  end

  // Retire counter, wraps naturally at 32 bits.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) retire_cnt_q <= '0;
    else            retire_cnt_q <= retire_cnt_d;
  end

  // A split at stage 0 consumes stage 0 itself, so input cannot enter then.
  assign in_ready_o    = adv[0] & ~(|flush_i) & ~(split_act && (SPLIT_STG == 0));
  assign adv_o         = adv;
  assign stage_valid_o = stg_v;
  assign stage_data_o  = stg_d;
  assign retire_cnt_o  = retire_cnt_q;

endmodule

// File: tb/tb_pipe_lanes.sv
// Directed bench for pipe_lanes (2 lanes, 5 stages, 64-bit payload).
module tb_pipe_lanes;

  localparam int L = 2;
  localparam int S = 5;
  localparam int W = 64;

  logic              clock_i = 1'b0;
  logic              reset_n_i;
  logic [L-1:0]      in_valid_i;
  logic [L*W-1:0]    in_data_i;
  logic              in_ready_o;
  logic [S-1:0]      stall_i, flush_i;
  logic [L-1:0]      split_i;
  logic [S*L-1:0]    stage_valid_o;
  logic [S*L*W-1:0]  stage_data_o;
  logic [S-1:0]      adv_o;
  logic [31:0]       retire_cnt_o;

  int checks = 0;
  int failures = 0;

  pipe_lanes #(.LANES(L), .STAGES(S), .DATA_W(W), .SPLIT_STG(2)) dut (
    .clock_i       (clock_i),
    .reset_n_i     (reset_n_i),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_ready_o    (in_ready_o),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .split_i       (split_i),
    .stage_valid_o (stage_valid_o),
    .stage_data_o  (stage_data_o),
    .adv_o         (adv_o),
    .retire_cnt_o  (retire_cnt_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic sv(input int s, input int l);
    return stage_valid_o[s*L+l];
  endfunction

  function automatic logic [W-1:0] sd(input int s, input int l);
    return stage_data_o[(s*L+l)*W +: W];
  endfunction

  function automatic logic [W-1:0] kd(input int k, input int l);
    return 64'(k * 256 + 'hA0 + l);
  endfunction

  task automatic step();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic feed(input logic [W-1:0] d0, input logic [W-1:0] d1);
    in_valid_i = 2'b11;
    in_data_i  = {d1, d0};
  endtask

  initial begin
    reset_n_i = 1'b0; in_valid_i = '0; in_data_i = '0;
    stall_i = '0; flush_i = '0; split_i = '0;
    step(); step();
    chk("rst_valid", 64'(stage_valid_o), 64'h0);
    chk("rst_data", 64'(|stage_data_o), 64'h0);
    chk("rst_cnt", 64'(retire_cnt_o), 64'h0);

    // 1: fill and stream, latency 5
    reset_n_i = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      feed(kd(n-1, 0), kd(n-1, 1));
      step();
      if (n == 5) begin
        chk("lat_v0", 64'(sv(4, 0)), 64'h1);
        chk("lat_v1", 64'(sv(4, 1)), 64'h1);
        chk("lat_d0", sd(4, 0), 64'hA0);
        chk("lat_d1", sd(4, 1), 64'hA1);
        chk("lat_cnt", 64'(retire_cnt_o), 64'd0);
      end
      if (n == 6) chk("ret_cnt6", 64'(retire_cnt_o), 64'd2);
      if (n == 7) begin
        chk("ret_cnt7", 64'(retire_cnt_o), 64'd4);
        chk("ret_d7", sd(4, 0), kd(2, 0));
      end
    end

    // 2: stall stage 3 for two cycles
    stall_i = 5'b01000;
    feed(kd(7, 0), kd(7, 1));
    #1;
    chk("stl_rdy", 64'(in_ready_o), 64'h0);
    chk("stl_adv", 64'(adv_o), 64'b10000);
    step();
    chk("stl_bub1", 64'(sv(4, 0)), 64'h0);
    chk("stl_cnt1", 64'(retire_cnt_o), 64'd6);
    #1;
    chk("stl_rdy2", 64'(in_ready_o), 64'h0);
    step();
    chk("stl_bub2", 64'(sv(4, 1)), 64'h0);
    chk("stl_s3", sd(3, 0), kd(3, 0));
    chk("stl_s0", sd(0, 0), kd(6, 0));
    chk("stl_cnt2", 64'(retire_cnt_o), 64'd6);
    stall_i = '0;
    step();
    chk("stl_rel_v", 64'(sv(4, 0)), 64'h1);
    chk("stl_rel_d", sd(4, 0), kd(3, 0));
    chk("stl_rel_s0", sd(0, 0), kd(7, 0));

    // 3: flush stage 2 with a full pipe
    flush_i = 5'b00100;
    feed(kd(8, 0), kd(8, 1));
    #1;
    chk("fl_rdy", 64'(in_ready_o), 64'h0);
    chk("fl_adv", 64'(adv_o), 64'b11111);
    step();
    chk("fl_s0v", 64'(sv(0, 0)), 64'h0);
    chk("fl_s1v", 64'(sv(1, 1)), 64'h0);
    chk("fl_s2v", 64'(sv(2, 0)), 64'h0);
    chk("fl_s2d", sd(2, 0), kd(5, 0));
    chk("fl_s3bub", 64'(sv(3, 0)), 64'h0);
    chk("fl_s4v", 64'(sv(4, 1)), 64'h1);
    chk("fl_s4d", sd(4, 1), kd(4, 1));
    chk("fl_cnt", 64'(retire_cnt_o), 64'd8);

    // 4: split lane 1 at stage 2
    flush_i = '0;
    feed(64'hB0, 64'hB1); step();
    feed(64'hC0, 64'hC1); step();
    feed(64'hD0, 64'hD1); step();
    chk("sp_pre", sd(2, 0), 64'hB0);
    chk("sp_cnt0", 64'(retire_cnt_o), 64'd10);
    split_i = 2'b10;
    feed(64'hE0, 64'hE1);
    #1;
    chk("sp_rdy", 64'(in_ready_o), 64'h0);
    chk("sp_adv", 64'(adv_o), 64'b11100);
    step();
    chk("sp_s3v0", 64'(sv(3, 0)), 64'h1);
    chk("sp_s3d0", sd(3, 0), 64'hB0);
    chk("sp_s3v1", 64'(sv(3, 1)), 64'h0);
    chk("sp_s2v1", 64'(sv(2, 1)), 64'h1);
    chk("sp_s2d1", sd(2, 1), 64'hB1);
    chk("sp_s2v0", 64'(sv(2, 0)), 64'h0);
    chk("sp_s1d", sd(1, 0), 64'hC0);
    chk("sp_s0d", sd(0, 0), 64'hD0);
    split_i = '0;
    #1;
    chk("sp_rdy2", 64'(in_ready_o), 64'h1);
    step();
    chk("sp2_s3v1", 64'(sv(3, 1)), 64'h1);
    chk("sp2_s3d1", sd(3, 1), 64'hB1);
    chk("sp2_s3v0", 64'(sv(3, 0)), 64'h0);
    chk("sp2_s4d0", sd(4, 0), 64'hB0);
    chk("sp2_s4v1", 64'(sv(4, 1)), 64'h0);
    chk("sp2_cnt", 64'(retire_cnt_o), 64'd10);
    in_valid_i = '0;
    step();
    chk("sp3_cnt", 64'(retire_cnt_o), 64'd11);
    chk("sp3_s4d1", sd(4, 1), 64'hB1);
    chk("sp3_s4v0", 64'(sv(4, 0)), 64'h0);

    // 5: stall and flush on stage 2 together
    stall_i = 5'b00100;
    flush_i = 5'b00100;
    feed(64'hF0, 64'hF1);
    #1;
    chk("sf_rdy", 64'(in_ready_o), 64'h0);
    chk("sf_adv", 64'(adv_o), 64'b11000);
    step();
    chk("sf_s1v", 64'(sv(1, 0)), 64'h0);
    chk("sf_s2v", 64'(sv(2, 1)), 64'h0);
    chk("sf_s2d", sd(2, 0), 64'hD0);
    chk("sf_s3v", 64'(sv(3, 1)), 64'h0);
    chk("sf_s4d", sd(4, 0), 64'hC0);
    chk("sf_cnt", 64'(retire_cnt_o), 64'd12);
    stall_i = '0;
    flush_i = '0;
    in_valid_i = '0;
    step();
    chk("sf_cnt2", 64'(retire_cnt_o), 64'd14);

    // 6: counter wrap
    feed(64'h60, 64'h61); step();
    in_valid_i = '0;
    for (int i = 0; i < 4; i++) step();
    chk("wr_s4d", sd(4, 1), 64'h61);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    chk("wr_pre", 64'(retire_cnt_o), 64'hFFFF_FFFF);
    step();
    chk("wr_post", 64'(retire_cnt_o), 64'h1);

    // reset mid-stream restarts empty
    feed(64'h70, 64'h71); step();
    chk("mr_pre", sd(0, 0), 64'h70);
    reset_n_i = 1'b0;
    step();
    chk("mr_valid", 64'(stage_valid_o), 64'h0);
    chk("mr_cnt", 64'(retire_cnt_o), 64'h0);
    reset_n_i = 1'b1;
    in_valid_i = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
